// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter slice.
//   WIDTH_DEF      default sample bits per channel
//   SCLK_HALF_DEF  default mclk strobes per sclk half-period
//   chan_e         lrck level encoding: LEFT = 0, RIGHT = 1
package i2s_pkg;

  localparam int unsigned WIDTH_DEF     = 16;
  localparam int unsigned SCLK_HALF_DEF = 4;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_sclk_gen.sv
// Serial bit clock generator: divides the mclk strobe by 2*SCLK_HALF.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   tick_i   one-clk mclk strobe
//   clr_i    synchronous clear (lrck edge); wins over tick_i
//   sclk_o   serial bit clock level
//   fall_o   one-clk strobe on the clk where sclk_o goes 1 -> 0
module i2s_sclk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_HALF = SCLK_HALF_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic fall_o
);

  localparam int unsigned PW = $clog2(SCLK_HALF) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SCLK_HALF - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    phase_d = phase_q;
    sclk_d  = sclk_q;
    wrap    = tick_i && (phase_q == PH_LAST);
    if (clr_i) begin
      phase_d = '0;
      sclk_d  = 1'b0;
    end else if (tick_i) begin
      if (wrap) begin
        phase_d = '0;
        sclk_d  = ~sclk_q;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign fall_o = ~clr_i & wrap & sclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S serial-data transmitter. Takes stereo pairs over valid/ready into a
// one-pair holding register, loads the shift registers at each left
// half-frame start (falling lrck) and shifts MSB-first on falling sclk with
// the one-sclk I2S delay.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   mclk_tick          master-clock strobe
//   lrck               0 = left half-frame, 1 = right half-frame
//   s_valid/s_ready    sample pair handshake; s_left/s_right samples
//   sclk, sdata        DAC serial clock and data
//   underrun           one-clk pulse: left half-frame started with no pair held
//   underrun_cnt       saturating underrun count (only with I2S_TX_UNDERRUN_CNT_EN)
// Build option: define I2S_TX_UNDERRUN_CNT_EN to add the underrun_cnt port.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned SCLK_HALF = SCLK_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mclk_tick,
  input  logic             lrck,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  output logic             s_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int unsigned BW = $clog2(WIDTH) + 1;

  logic             lrck_q;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] shl_q, shl_d, shr_q, shr_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;

  logic lrck_edge, lrck_fall, accept, sclk_fall;

  assign lrck_edge = lrck ^ lrck_q;
  assign lrck_fall = lrck_edge && (lrck == LEFT);
  assign accept    = s_valid & ~hold_full_q;

  i2s_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .tick_i  (mclk_tick),
    .clr_i   (lrck_edge),
    .sclk_o  (sclk),
    .fall_o  (sclk_fall)
  );

  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shl_d       = shl_q;
    shr_d       = shr_q;
    bit_idx_d   = bit_idx_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;

    // accept and a loading fall are exclusive: accept needs an empty hold
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left;
      hold_r_d    = s_right;
    end

    if (lrck_fall) begin
      if (hold_full_q) begin
        shl_d       = hold_l_q;
        shr_d       = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        shl_d      = '0;
        shr_d      = '0;
        underrun_d = 1'b1;
      end
    end

    // sdata deliberately holds its last bit across an lrck edge
    if (lrck_edge) begin
      bit_idx_d = '0;
    end else if (sclk_fall) begin
      if (bit_idx_q < BW'(WIDTH)) begin
        bit_idx_d = bit_idx_q + 1'b1;
        if (lrck_q == RIGHT) begin
          sdata_d = shr_q[WIDTH-1];
          shr_d   = {shr_q[WIDTH-2:0], 1'b0};
        end else begin
          sdata_d = shl_q[WIDTH-1];
          shl_d   = {shl_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shl_q       <= '0;
      shr_q       <= '0;
      bit_idx_q   <= '0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      lrck_q      <= lrck;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      bit_idx_q   <= bit_idx_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_ready  = ~hold_full_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: table-driven frames, hand sequences for the
// multi-cycle corners and randomized frames, all checked against a
// behavioural per-clock model of the serial stream.
module tb_i2s_tx;

  localparam int W          = 16;
  localparam int SH         = 4;
  localparam int TICK_DIV   = 5;
  localparam int HALF_TICKS = 257;

  logic        clk = 1'b0;
  logic        rst_n, mclk_tick, lrck, s_valid;
  logic [15:0] s_left, s_right;
  logic        s_ready, sclk, sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(W), .SCLK_HALF(SH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mclk_tick (mclk_tick),
    .lrck      (lrck),
    .s_valid   (s_valid),
    .s_left    (s_left),
    .s_right   (s_right),
    .s_ready   (s_ready),
    .sclk      (sclk),
    .sdata     (sdata),
    .underrun  (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // stimulus stream state
  int cyc    = 0;
  int tcount = 0;

  task automatic drive_next();
    cyc++;
    mclk_tick = ((cyc % TICK_DIV) == 0);
    if (mclk_tick) begin
      tcount++;
      if (tcount == HALF_TICKS) begin
        tcount = 0;
        lrck   = ~lrck;
      end
    end
  endtask

  // behavioural model
  logic        m_lrck, m_hold_full, m_sclk, m_sdata, m_und;
  logic [15:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r, m_cnt;
  int          m_ticks, m_nbit;

  task automatic model_reset();
    m_lrck = 0; m_hold_full = 0; m_sclk = 0; m_sdata = 0; m_und = 0;
    m_hold_l = 0; m_hold_r = 0; m_cur_l = 0; m_cur_r = 0; m_cnt = 0;
    m_ticks = 0; m_nbit = 0;
  endtask

  task automatic step(output bit e, output bit f, output bit tk);
    logic lr_s, v_s, tk_s, sclk_b;
    logic [15:0] l_s, r_s, word;
    bit acc;
    lr_s = lrck; v_s = s_valid; tk_s = mclk_tick; l_s = s_left; r_s = s_right;
    sclk_b = sclk;
    @(posedge clk);
    #1;
    m_und = 0;
    e   = (lr_s != m_lrck);
    acc = v_s && !m_hold_full;
    if (e) begin
      if (lr_s == 1'b0) begin
        if (m_hold_full) begin
          m_cur_l = m_hold_l; m_cur_r = m_hold_r; m_hold_full = 0;
        end else begin
          m_cur_l = 0; m_cur_r = 0; m_und = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      m_lrck = lr_s; m_ticks = 0; m_nbit = 0; m_sclk = 0;
    end else if (tk_s) begin
      m_ticks++;
      m_sclk = (((m_ticks / SH) % 2) == 1);
      if ((m_ticks % (2 * SH)) == 0) begin
        word = m_lrck ? m_cur_r : m_cur_l;
        if (m_nbit < W) begin
          m_sdata = word[W-1-m_nbit];
          m_nbit++;
        end else begin
          m_sdata = 0;
        end
      end
    end
    if (acc) begin
      m_hold_full = 1; m_hold_l = l_s; m_hold_r = r_s;
    end
    check("s_ready", s_ready, !m_hold_full);
    check("sclk", sclk, m_sclk);
    check("sdata", sdata, m_sdata);
    check("underrun", underrun, m_und);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_cnt);
`endif
    f  = sclk_b && !sclk && !e;
    tk = tk_s;
    drive_next();
  endtask

  task automatic run_until_edge(output logic [15:0] got, output bit extra,
                                output int nfall, output int nund);
    bit e, f, tk, done;
    got = 0; extra = 0; nfall = 0; nund = 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step(e, f, tk);
      if (underrun) nund++;
      if (e) done = 1;
      else if (f) begin
        if (nfall < W) got = {got[14:0], sdata};
        else if (sdata) extra = 1;
        nfall++;
      end
    end
    if (!done) check("edge_timeout", 0, 1);
  endtask

  task automatic check_half(input string nm, input logic [15:0] got, input bit extra,
                            input int nfall, input logic [15:0] exp);
    check({nm, "_word"}, got, exp);
    check({nm, "_tail"}, extra, 0);
    check({nm, "_nfall"}, nfall, 32);
  endtask

  bit          pend = 0;
  logic [15:0] pend_r = 0;
  string       pend_name = "";

  // Entered at the start of a right half-frame; submits the pair (if any),
  // checks the previous right half, then this frame's left half.
  task automatic do_frame(input logic [15:0] l, input logic [15:0] r, input bit present,
                          input logic [15:0] exp_l, input logic [15:0] exp_r,
                          input int exp_und, input string nm);
    logic [15:0] got;
    bit extra, e, f, tk;
    int nfall, nu, nu_total;
    if (present) begin
      s_valid = 1; s_left = l; s_right = r;
      step(e, f, tk);
      s_valid = 0;
    end
    run_until_edge(got, extra, nfall, nu);
    nu_total = nu;
    if (pend) check_half({pend_name, "_R"}, got, extra, nfall, pend_r);
    run_until_edge(got, extra, nfall, nu);
    nu_total += nu;
    check_half({nm, "_L"}, got, extra, nfall, exp_l);
    check({nm, "_underrun_pulses"}, nu_total, exp_und);
    pend = 1; pend_r = exp_r; pend_name = nm;
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          present;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          exp_und;
    string       name;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got, rl, rr;
    bit extra, e, f, tk, pr;
    int nfall, nu, nu2, nt;

    tbl[0] = '{16'hA5C3, 16'h0F0F, 1'b1, 16'hA5C3, 16'h0F0F, 0, "pairA5C3"};
    tbl[1] = '{16'h1111, 16'h2222, 1'b0, 16'h0000, 16'h0000, 1, "starved"};
    tbl[2] = '{16'h1234, 16'hFEDC, 1'b1, 16'h1234, 16'hFEDC, 0, "pair1234"};
    tbl[3] = '{16'h8000, 16'h7FFF, 1'b1, 16'h8000, 16'h7FFF, 0, "extremes"};
    tbl[4] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0001, 0, "ones"};

    mclk_tick = 0; lrck = 0; s_valid = 0; s_left = 0; s_right = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check("rst_sclk", sclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_underrun", underrun, 0);
    repeat (2) begin @(posedge clk); #1; drive_next(); end
    rst_n = 1;
    model_reset();

    // align to the start of a right half-frame
    run_until_edge(got, extra, nfall, nu);
    if (m_lrck == 1'b0) run_until_edge(got, extra, nfall, nu);

    for (int i = 0; i < 5; i++)
      do_frame(tbl[i].l, tbl[i].r, tbl[i].present, tbl[i].exp_l, tbl[i].exp_r,
               tbl[i].exp_und, tbl[i].name);

    // held s_valid while the hold register is full
    s_valid = 1; s_left = 16'hC0DE; s_right = 16'h1357;
    step(e, f, tk);
    check("t4_ready_low", s_ready, 0);
    s_left = 16'h6B2D; s_right = 16'h9E41;
    run_until_edge(got, extra, nfall, nu);
    check_half({pend_name, "_R"}, got, extra, nfall, pend_r);
    check("t4_ready_at_fall", s_ready, 1);
    step(e, f, tk);
    check("t4_p2_taken", s_ready, 0);
    s_valid = 0;
    run_until_edge(got, extra, nfall, nu2);
    check_half("t4_p1_L", got, extra, nfall, 16'hC0DE);
    check("t4_underrun_pulses", nu + nu2, 0);
    run_until_edge(got, extra, nfall, nu);
    check_half("t4_p1_R", got, extra, nfall, 16'h1357);
    run_until_edge(got, extra, nfall, nu);
    check_half("t4_p2_L", got, extra, nfall, 16'h6B2D);
    pend = 1; pend_r = 16'h9E41; pend_name = "t4_p2";

    // lrck edge that coincides with an mclk tick
    check("t5_sclk_low_at_edge", sclk, 0);
    nt = 0;
    for (int i = 0; i < 200 && !sclk; i++) begin
      step(e, f, tk);
      if (tk) nt++;
    end
    check("t5_ticks_to_rise", nt, SH);
    pend = 0;

    for (int i = 0; i < 3; i++) begin
      rl = 16'($urandom); rr = 16'($urandom);
      pr = ($urandom_range(0, 3) != 0);
      do_frame(rl, rr, pr, pr ? rl : 16'h0, pr ? rr : 16'h0, pr ? 0 : 1, $sformatf("rnd%0d", i));
    end

    // asynchronous reset in the middle of a left half-frame
    run_until_edge(got, extra, nfall, nu);
    check_half({pend_name, "_R"}, got, extra, nfall, pend_r);
    s_valid = 1; s_left = 16'hBEEF; s_right = 16'hCAFE;
    step(e, f, tk);
    s_valid = 0;
    for (int i = 0; i < 200 && !sclk; i++) step(e, f, tk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_sdata", sdata, 0);
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_underrun", underrun, 0);
    repeat (3) begin @(posedge clk); #1; drive_next(); end
    rst_n = 1;
    model_reset();
    run_until_edge(got, extra, nfall, nu);
    check("post_rst_L_word", got, 0);
    check("post_rst_L_tail", extra, 0);
    pend = 1; pend_r = 16'h0000; pend_name = "post_rst";

`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("cnt_after_reset", underrun_cnt, 0);
    for (int i = 0; i < 3; i++)
      do_frame(16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1, $sformatf("cnt%0d", i));
    check("cnt_three", underrun_cnt, 3);
    force dut.underrun_cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step(e, f, tk);
    release dut.underrun_cnt_q;
    for (int i = 0; i < 2; i++)
      do_frame(16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1, $sformatf("sat%0d", i));
    check("cnt_saturated", underrun_cnt, 16'hFFFF);
`endif

    do_frame(16'h5A5A, 16'hC001, 1'b1, 16'h5A5A, 16'hC001, 0, "final");
    run_until_edge(got, extra, nfall, nu);
    check_half({pend_name, "_R"}, got, extra, nfall, pend_r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
